alu_cmd_issue: RTL and testbench
================================

# alu_cmd_issue

Command front-end that sits directly upstream of the combinational 4-bit ALU. It buffers operand/opcode commands in a small FIFO and drives them onto the ALU inputs one at a time from registers. It captures the ALU outputs one cycle later and returns a normalised result through a valid/ready response port. The block masks the ALU's undefined or stale outputs (carry, mul_out) and flags divide/modulo by zero.

## Interface
- DEPTH, 4, command FIFO entries; power of 2, ≥ 2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals (count < DEPTH)
- cmd_a, cmd_b  in  4 each  operands
- cmd_sel  in  4  ALU opcode
- alu_a, alu_b, alu_sel  out  4 each  registered drive to ALU a/b/sel
- alu_c  in  4  ALU c
- alu_carry  in  1  ALU carry
- alu_mul  in  8  ALU mul_out
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer accepts
- rsp_data  out  8  normalised result
- rsp_carry  out  1  add carry-out
- rsp_sel  out  4  opcode that produced rsp_data
- rsp_dz  out  1  divide/modulo by zero
- count  out  log2(DEPTH)+1  FIFO occupancy

## Operation

**FIFO**
- Push on cmd_valid & cmd_ready.
- Pop when the FSM loads operands.
- Read/write pointers wrap modulo DEPTH.
- Push and pop on the same edge leave count unchanged.
- A push at full cannot occur, because cmd_ready is 0.

**FSM states**
- IDLE
  - rsp_valid = 0.
  - If count > 0: load the head entry into alu_a/alu_b/alu_sel, pop, go to EXEC.
- EXEC
  - ALU inputs are stable for this full cycle.
  - At the end of the cycle, capture the result register and go to HOLD.
- HOLD
  - rsp_valid = 1.
  - On rsp_ready with count > 0: load the next head entry and pop on the same edge, go to EXEC.
  - On rsp_ready with count = 0: go to IDLE.
  - Otherwise stay in HOLD; all rsp_* outputs hold their values.

**Normalisation (applied at capture, using the registered alu_sel/alu_b)**
- sel 0000: rsp_data = {4'b0, alu_c}; rsp_carry = alu_carry.
- sel 0010: rsp_data = alu_mul.
- sel 0011 or 0100 with alu_b = 0: rsp_data = 8'h00; rsp_dz = 1.
- All other cases: rsp_data = {4'b0, alu_c}.
- rsp_carry = 0 and rsp_dz = 0 except where stated above.
- rsp_sel = alu_sel.
- alu_a/alu_b/alu_sel hold their last loaded values outside EXEC.

**Reset (rst_n low, asynchronous, including mid-operation)**
- Pointers, count and the FSM (to IDLE) clear.
- alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_sel and rsp_dz go to 0.
- FIFO contents and any in-flight or held result are discarded.
- cmd_ready reads 1; pushes are ignored while rst_n is low.

## Timing
- Command accepted at edge E0 with the block idle:
  - operands on alu_* after E1;
  - rsp_valid = 1 after E2.
- Latency is 2 cycles.
- Sustained throughput is one result per 2 cycles when rsp_ready is held high.
- A result is accepted on an edge where rsp_valid & rsp_ready. If the FIFO is non-empty, the next operands load on that same edge, so there is no idle bubble.
- cmd_ready depends only on count; it has no combinational path from rsp_ready or cmd_valid.
- An entry pushed into an empty FIFO at edge E is visible to the FSM in the following cycle, not at E.
- A pop at the same edge as a push at count = DEPTH−1 leaves count = DEPTH−1, and cmd_ready stays 1.

## Test plan
- **Add:** push a=9, b=8, sel=0000 with rsp_ready=1. Expect rsp_valid 2 cycles after acceptance, rsp_data=8'h01, rsp_carry=1, rsp_sel=0000, rsp_dz=0.
- **Multiply, then bitwise AND:** push a=15, b=15, sel=0010, then a=12, b=10, sel=1010. Expect rsp_data=8'hE1 (carry 0), then rsp_data=8'h08 with rsp_carry=0, not a stale value.
- **Divide/modulo by zero:** push a=7, b=0, sel=0011, then the same with sel=0100. Expect both responses rsp_data=8'h00, rsp_dz=1. Then push a=7, b=2, sel=0011; expect rsp_data=8'h03, rsp_dz=0.
- **Backpressure and full:** hold rsp_ready=0 and push 5 commands. Expect 4 accepted, then cmd_ready=0, count=4, first result stable in HOLD. Release rsp_ready; expect 5 results in order, 2 cycles apart, and cmd_ready back to 1 after the first pop.
- **Simultaneous push/pop:** with count=3, a push coincides with an operand load. Expect count to stay 3 and pointers to wrap past DEPTH−1 with order preserved.
- **Reset mid-operation:** assert rst_n low during EXEC with 2 entries queued. Expect all outputs 0 and count=0 immediately. After release, expect no stale responses; a new command returns after 2 cycles.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: command FIFO and issue sequencer in front of a combinational
// 4-bit ALU. Operands are driven from registers, the ALU result is captured
// one cycle later, normalised, and presented on a valid/ready response port.
module alu_cmd_issue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [3:0]               cmd_a,
   input  logic [3:0]               cmd_b,
   input  logic [3:0]               cmd_sel,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   output logic [3:0]               alu_sel,
   input  logic [3:0]               alu_c,
   input  logic                     alu_carry,
   input  logic [7:0]               alu_mul,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [7:0]               rsp_data,
   output logic                     rsp_carry,
   output logic [3:0]               rsp_sel,
   output logic                     rsp_dz,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Result normalisation: returns {dz, carry, data}. Carry and mul_out are
   // only meaningful for add and multiply; everywhere else they are masked.
   function automatic logic [9:0] normalise(
      input logic [3:0] sel,
      input logic [3:0] b,
      input logic [3:0] c,
      input logic       carry,
      input logic [7:0] mul
   );
      logic [9:0] r;
      r = {1'b0, 1'b0, 4'h0, c};
      case (sel)
         4'b0000: r = {1'b0, carry, 4'h0, c};
         4'b0010: r = {1'b0, 1'b0, mul};
         4'b0011,
         4'b0100: begin
            if (b == 4'h0) begin
               r = {1'b1, 1'b0, 8'h00};
            end else begin
               r = {1'b0, 1'b0, 4'h0, c};
            end
         end
         default: r = {1'b0, 1'b0, 4'h0, c};
      endcase
      return r;
   endfunction

   logic [11:0]   mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nx_s;
   logic          cmd_ready_r;
   state_t        state_r;
   state_t        state_nx_s;
   logic          load_s;
   logic          capture_s;
   logic          push_s;
   logic [11:0]   head_s;
   logic [9:0]    norm_s;
   logic [3:0]    alu_a_r;
   logic [3:0]    alu_b_r;
   logic [3:0]    alu_sel_r;
   logic          rsp_valid_r;
   logic [7:0]    rsp_data_r;
   logic          rsp_carry_r;
   logic [3:0]    rsp_sel_r;
   logic          rsp_dz_r;

   assign push_s = cmd_valid & cmd_ready_r;
   assign head_s = mem_r[rd_ptr_r];
   assign norm_s = normalise(alu_sel_r, alu_b_r, alu_c, alu_carry, alu_mul);

   // Occupancy update: a push and a pop on the same edge cancel out.
   always_comb begin
      count_nx_s = count_r;
      case ({push_s, load_s})
         2'b10:   count_nx_s = count_r + CW'(1);
         2'b01:   count_nx_s = count_r - CW'(1);
         default: count_nx_s = count_r;
      endcase
   end

   // FIFO storage write; contents need no reset because count gates every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {cmd_a, cmd_b, cmd_sel};
      end
   end

   // FIFO pointers, occupancy and the registered ready flag derived from it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         cmd_ready_r <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (load_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r     <= count_nx_s;
         cmd_ready_r <= (count_nx_s < CW'(DEPTH));
      end
   end

   // Issue sequencer next-state logic: load from FIFO, execute one cycle, hold result.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      capture_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (count_r != '0) begin
               load_s     = 1'b1;
               state_nx_s = EXEC;
            end else begin
               state_nx_s = IDLE;
            end
         end
         EXEC: begin
            capture_s  = 1'b1;
            state_nx_s = HOLD;
         end
         HOLD: begin
            if (rsp_ready) begin
               if (count_r != '0) begin
                  load_s     = 1'b1;
                  state_nx_s = EXEC;
               end else begin
                  state_nx_s = IDLE;
               end
            end else begin
               state_nx_s = HOLD;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register plus registered response-valid that tracks the HOLD state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         rsp_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         rsp_valid_r <= (state_nx_s == HOLD);
      end
   end

   // ALU operand registers, loaded from the FIFO head on each pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_r   <= 4'h0;
         alu_b_r   <= 4'h0;
         alu_sel_r <= 4'h0;
      end else if (load_s) begin
         alu_a_r   <= head_s[11:8];
         alu_b_r   <= head_s[7:4];
         alu_sel_r <= head_s[3:0];
      end
   end

   // Response capture at the end of EXEC; values hold until the next capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_r  <= 8'h00;
         rsp_carry_r <= 1'b0;
         rsp_dz_r    <= 1'b0;
         rsp_sel_r   <= 4'h0;
      end else if (capture_s) begin
         rsp_data_r  <= norm_s[7:0];
         rsp_carry_r <= norm_s[8];
         rsp_dz_r    <= norm_s[9];
         rsp_sel_r   <= alu_sel_r;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign count     = count_r;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_sel   = alu_sel_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_carry = rsp_carry_r;
   assign rsp_sel   = rsp_sel_r;
   assign rsp_dz    = rsp_dz_r;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: directed bench for alu_cmd_issue with a behavioural 4-bit
// ALU attached; expected responses are hand-computed constants.
module tb_alu_cmd_issue;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a, cmd_b, cmd_sel;
   logic [3:0] alu_a, alu_b, alu_sel;
   logic [3:0] alu_c;
   logic       alu_carry;
   logic [7:0] alu_mul;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_carry;
   logic [3:0] rsp_sel;
   logic       rsp_dz;
   logic [2:0] count;

   int tests_run = 0;
   int tests_failed = 0;

   logic [4:0] sum_s;

   // Backpressure command set: four to be accepted, the fifth refused.
   logic [3:0] bp_a   [5] = '{4'd3, 4'd5, 4'd9, 4'd14, 4'd15};
   logic [3:0] bp_b   [5] = '{4'd4, 4'd3, 4'd5, 4'd3,  4'd15};
   logic [3:0] bp_sel [5] = '{4'h0, 4'h2, 4'hA, 4'h3,  4'h0};
   logic [7:0] bp_exp [4] = '{8'h07, 8'h0F, 8'h01, 8'h04};

   always #5 clk = ~clk;

   alu_cmd_issue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_sel   (cmd_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_c     (alu_c),
      .alu_carry (alu_carry),
      .alu_mul   (alu_mul),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_sel   (rsp_sel),
      .rsp_dz    (rsp_dz),
      .count     (count)
   );

   // Behavioural ALU: carry and mul_out are always driven, even for opcodes
   // where they are meaningless, so masking in the DUT is exercised.
   assign sum_s     = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_carry = sum_s[4];
   assign alu_mul   = {4'h0, alu_a} * {4'h0, alu_b};

   always_comb begin
      alu_c = alu_a ^ alu_b;
      case (alu_sel)
         4'h0:    alu_c = sum_s[3:0];
         4'h1:    alu_c = alu_a - alu_b;
         4'h2:    alu_c = alu_mul[3:0];
         4'h3:    alu_c = (alu_b == 4'h0) ? 4'hF : alu_a / alu_b;
         4'h4:    alu_c = (alu_b == 4'h0) ? 4'hF : alu_a % alu_b;
         4'hA:    alu_c = alu_a & alu_b;
         default: alu_c = alu_a ^ alu_b;
      endcase
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_a = a;
      cmd_b = b;
      cmd_sel = s;
      while (cmd_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk_eq("push_rdy", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk_eq(tag, 32'(rsp_valid), 32'd1);
   endtask

   task automatic wait_rsp(input string tag, input logic [7:0] d, input logic c,
                           input logic [3:0] s, input logic z);
      wait_valid({tag, "_vld"});
      chk_eq({tag, "_data"},  32'(rsp_data),  32'(d));
      chk_eq({tag, "_carry"}, 32'(rsp_carry), 32'(c));
      chk_eq({tag, "_sel"},   32'(rsp_sel),   32'(s));
      chk_eq({tag, "_dz"},    32'(rsp_dz),    32'(z));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_a = 4'h0;
      cmd_b = 4'h0;
      cmd_sel = 4'h0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);

      // reset state
      chk_eq("rst_count", 32'(count), 32'd0);
      chk_eq("rst_ready", 32'(cmd_ready), 32'd1);
      chk_eq("rst_valid", 32'(rsp_valid), 32'd0);
      chk_eq("rst_alu_a", 32'(alu_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // add with explicit latency
      cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd8; cmd_sel = 4'h0;
      chk_eq("add_rdy", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk_eq("add_cnt1", 32'(count), 32'd1);
      chk_eq("add_v0", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk_eq("add_alu_a", 32'(alu_a), 32'd9);
      chk_eq("add_alu_b", 32'(alu_b), 32'd8);
      chk_eq("add_alu_sel", 32'(alu_sel), 32'd0);
      chk_eq("add_v1", 32'(rsp_valid), 32'd0);
      chk_eq("add_cnt0", 32'(count), 32'd0);
      @(negedge clk);
      chk_eq("add_vld", 32'(rsp_valid), 32'd1);
      chk_eq("add_data", 32'(rsp_data), 32'h01);
      chk_eq("add_carry", 32'(rsp_carry), 32'd1);
      chk_eq("add_sel", 32'(rsp_sel), 32'd0);
      chk_eq("add_dz", 32'(rsp_dz), 32'd0);
      @(negedge clk);
      chk_eq("add_done", 32'(rsp_valid), 32'd0);

      // multiply then AND: carry and mul_out must be masked on AND
      push(4'd15, 4'd15, 4'h2);
      push(4'd12, 4'd10, 4'hA);
      wait_rsp("mul", 8'hE1, 1'b0, 4'h2, 1'b0);
      wait_rsp("and", 8'h08, 1'b0, 4'hA, 1'b0);

      // divide/modulo by zero, then a normal divide
      push(4'd7, 4'd0, 4'h3);
      push(4'd7, 4'd0, 4'h4);
      wait_rsp("div0", 8'h00, 1'b0, 4'h3, 1'b1);
      wait_rsp("mod0", 8'h00, 1'b0, 4'h4, 1'b1);
      push(4'd7, 4'd2, 4'h3);
      wait_rsp("div", 8'h03, 1'b0, 4'h3, 1'b0);

      // backpressure and full
      rsp_ready = 1'b0;
      push(4'd1, 4'd2, 4'h0);
      wait_valid("bp_hold_vld");
      chk_eq("bp_hold_data", 32'(rsp_data), 32'h03);
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd_a = bp_a[i];
         cmd_b = bp_b[i];
         cmd_sel = bp_sel[i];
         chk_eq($sformatf("bp_rdy%0d", i), 32'(cmd_ready), (i < 4) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk_eq("bp_cnt", 32'(count), 32'd4);
      chk_eq("bp_full", 32'(cmd_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk_eq("bp_still_vld", 32'(rsp_valid), 32'd1);
      chk_eq("bp_still_data", 32'(rsp_data), 32'h03);
      chk_eq("bp_still_cnt", 32'(count), 32'd4);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk_eq("bp_rel_rdy", 32'(cmd_ready), 32'd1);
      chk_eq("bp_rel_cnt", 32'(count), 32'd3);
      chk_eq("bp_rel_vld", 32'(rsp_valid), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk_eq($sformatf("bp_r%0d_vld", k), 32'(rsp_valid), 32'd1);
         chk_eq($sformatf("bp_r%0d_data", k), 32'(rsp_data), 32'(bp_exp[k]));
         if (k < 3) begin
            @(negedge clk);
            chk_eq($sformatf("bp_r%0d_gap", k), 32'(rsp_valid), 32'd0);
         end
      end
      @(negedge clk);
      chk_eq("bp_end_vld", 32'(rsp_valid), 32'd0);
      chk_eq("bp_end_cnt", 32'(count), 32'd0);

      // simultaneous push/pop at count 3, pointers wrap
      rsp_ready = 1'b0;
      push(4'd2, 4'd3, 4'h0);
      wait_valid("sp_hold_vld");
      chk_eq("sp_hold_data", 32'(rsp_data), 32'h05);
      push(4'd6, 4'd7, 4'h2);
      push(4'd13, 4'd4, 4'h4);
      push(4'd15, 4'd1, 4'h0);
      chk_eq("sp_cnt3", 32'(count), 32'd3);
      cmd_valid = 1'b1; cmd_a = 4'd12; cmd_b = 4'd10; cmd_sel = 4'hA;
      rsp_ready = 1'b1;
      chk_eq("sp_rdy", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk_eq("sp_cnt_keep", 32'(count), 32'd3);
      chk_eq("sp_rdy_keep", 32'(cmd_ready), 32'd1);
      wait_rsp("sp1", 8'h2A, 1'b0, 4'h2, 1'b0);
      wait_rsp("sp2", 8'h01, 1'b0, 4'h4, 1'b0);
      wait_rsp("sp3", 8'h00, 1'b1, 4'h0, 1'b0);
      wait_rsp("sp4", 8'h08, 1'b0, 4'hA, 1'b0);

      // reset during EXEC with two entries queued
      rsp_ready = 1'b0;
      push(4'd1, 4'd1, 4'h0);
      wait_valid("rm_hold_vld");
      push(4'd5, 4'd6, 4'h2);
      push(4'd3, 4'd3, 4'h0);
      push(4'd2, 4'd2, 4'h0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk_eq("rm_exec_cnt", 32'(count), 32'd2);
      chk_eq("rm_exec_a", 32'(alu_a), 32'd5);
      #1 rst_n = 1'b0;
      #1;
      chk_eq("rm_cnt", 32'(count), 32'd0);
      chk_eq("rm_rdy", 32'(cmd_ready), 32'd1);
      chk_eq("rm_vld", 32'(rsp_valid), 32'd0);
      chk_eq("rm_alu_a", 32'(alu_a), 32'd0);
      chk_eq("rm_alu_b", 32'(alu_b), 32'd0);
      chk_eq("rm_alu_sel", 32'(alu_sel), 32'd0);
      chk_eq("rm_data", 32'(rsp_data), 32'd0);
      chk_eq("rm_carry", 32'(rsp_carry), 32'd0);
      chk_eq("rm_sel", 32'(rsp_sel), 32'd0);
      chk_eq("rm_dz", 32'(rsp_dz), 32'd0);
      cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd9; cmd_sel = 4'h0;
      repeat (2) @(negedge clk);
      chk_eq("rm_push_ign", 32'(count), 32'd0);
      cmd_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk_eq("rm_no_stale", 32'(rsp_valid), 32'd0);
      chk_eq("rm_post_cnt", 32'(count), 32'd0);
      cmd_valid = 1'b1; cmd_a = 4'd4; cmd_b = 4'd4; cmd_sel = 4'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk_eq("rm_new_cnt", 32'(count), 32'd1);
      @(negedge clk);
      chk_eq("rm_new_v1", 32'(rsp_valid), 32'd0);
      chk_eq("rm_new_a", 32'(alu_a), 32'd4);
      @(negedge clk);
      chk_eq("rm_new_vld", 32'(rsp_valid), 32'd1);
      chk_eq("rm_new_data", 32'(rsp_data), 32'h08);
      chk_eq("rm_new_carry", 32'(rsp_carry), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
